n64_controller_responder: RTL and testbench

- Controller-side end of the N64 single-wire joybus protocol; emulates a standard controller on the bus pin.
- Decodes host command bytes from the pin and answers as a real pad would.
  - 0x01 (poll buttons): answers with the 32-bit button word.
  - 0x00 (status) and 0xFF (reset + status): answers with the 24-bit status word.
- Used as the device-under-test partner for the host poller in loopback benches.
- Also used as a standalone pad emulator driven by fabric button logic.

---
 rtl/n64_controller_responder.sv | 219 +++++++++++++++++++++
 tb/tb_n64_controller_responder.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/n64_controller_responder.sv
// Controller-side joybus endpoint: decodes host command bytes from the open-collector pin
// and replies with the button word (0x01) or the status word (0x00 / 0xFF).
module n64_controller_responder #(
    parameter int unsigned CLKS_PER_US   = 100,
    parameter logic [23:0] STATUS_WORD   = 24'h050002,
    parameter int unsigned TURNAROUND_US = 2,
    parameter int unsigned RX_TIMEOUT_US = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    inout  wire         fab_pin,
    input  logic [31:0] button_data,
    input  logic        respond_enable,
    output logic [7:0]  cmd_byte,
    output logic        cmd_valid,
    output logic        reset_req,
    output logic        busy,
    output logic        rx_error
);

    localparam logic [2:0] StIdle       = 3'd0;
    localparam logic [2:0] StRxBit      = 3'd1;
    localparam logic [2:0] StRxStop     = 3'd2;
    localparam logic [2:0] StTurnaround = 3'd3;
    localparam logic [2:0] StTxBit      = 3'd4;
    localparam logic [2:0] StTxStop     = 3'd5;
    localparam logic [2:0] StWaitIdle   = 3'd6;

    localparam logic [15:0] T1      = 16'(CLKS_PER_US);
    localparam logic [15:0] T2      = 16'(2 * CLKS_PER_US);
    localparam logic [15:0] T3      = 16'(3 * CLKS_PER_US);
    localparam logic [15:0] SampleAt = 16'(2 * CLKS_PER_US - 1);
    localparam logic [15:0] SlotEnd = 16'(4 * CLKS_PER_US - 1);
    localparam logic [15:0] LowMax  = 16'(5 * CLKS_PER_US);
    localparam logic [15:0] TaEnd   = 16'(TURNAROUND_US * CLKS_PER_US - 1);
    localparam logic [15:0] HighMax = 16'(RX_TIMEOUT_US * CLKS_PER_US - 1);

    logic [2:0]  state_q, state_d;
    logic [15:0] timer_q, timer_d, timer_inc;
    logic [15:0] high_cnt_q, high_cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic        sampled_q, sampled_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [7:0]  cmd_byte_q, cmd_byte_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic        reset_req_q, reset_req_d;
    logic        rx_error_q, rx_error_d;
    logic        busy_q, busy_d;
    logic        drive_low_q, drive_low_d;
    logic [31:0] tx_shift_q, tx_shift_d;
    logic [5:0]  tx_len_q, tx_len_d;
    logic [5:0]  tx_cnt_q, tx_cnt_d;
    logic        pin_meta_q, pin_sync_q, pin_prev_q;
    logic        fall;

    assign fab_pin   = drive_low_q ? 1'b0 : 1'bz;
    assign fall      = pin_prev_q & ~pin_sync_q;
    assign timer_inc = (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;

    assign cmd_byte  = cmd_byte_q;
    assign cmd_valid = cmd_valid_q;
    assign reset_req = reset_req_q;
    assign busy      = busy_q;
    assign rx_error  = rx_error_q;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_inc;
        high_cnt_d  = pin_sync_q ? ((high_cnt_q == 16'hFFFF) ? high_cnt_q : high_cnt_q + 16'd1)
                                 : 16'd0;
        bit_cnt_d   = bit_cnt_q;
        sampled_d   = sampled_q;
        rx_shift_d  = rx_shift_q;
        cmd_byte_d  = cmd_byte_q;
        cmd_valid_d = 1'b0;
        reset_req_d = 1'b0;
        rx_error_d  = 1'b0;
        tx_shift_d  = tx_shift_q;
        tx_len_d    = tx_len_q;
        tx_cnt_d    = tx_cnt_q;

        case (state_q)
            StIdle: begin
                timer_d = 16'd0;
                if (fall) begin
                    state_d   = StRxBit;
                    bit_cnt_d = 4'd0;
                    sampled_d = 1'b0;
                end
            end
            StRxBit: begin
                if (!sampled_q) begin
                    if (timer_q == SampleAt) begin
                        rx_shift_d = {rx_shift_q[6:0], pin_sync_q};
                        bit_cnt_d  = bit_cnt_q + 4'd1;
                        sampled_d  = 1'b1;
                    end
                end else if (fall) begin
                    timer_d   = 16'd0;
                    sampled_d = 1'b0;
                    if (bit_cnt_q == 4'd8) begin
                        state_d = StRxStop;
                    end
                end else if (pin_sync_q) begin
                    // Host went quiet mid-frame: drop the partial byte.
                    if (high_cnt_q >= HighMax) begin
                        rx_error_d = 1'b1;
                        state_d    = StIdle;
                    end
                end else if (timer_q >= LowMax) begin
                    rx_error_d = 1'b1;
                    state_d    = StWaitIdle;
                end
            end
            StRxStop: begin
                if (pin_sync_q) begin
                    cmd_byte_d  = rx_shift_q;
                    cmd_valid_d = 1'b1;
                    reset_req_d = (rx_shift_q == 8'hFF);
                    timer_d     = 16'd0;
                    state_d     = StTurnaround;
                end else if (timer_q >= SampleAt) begin
                    rx_error_d = 1'b1;
                    state_d    = StWaitIdle;
                end
            end
            StTurnaround: begin
                if (timer_q == TaEnd) begin
                    timer_d  = 16'd0;
                    tx_cnt_d = 6'd0;
                    if (respond_enable && cmd_byte_q == 8'h01) begin
                        tx_shift_d = button_data;
                        tx_len_d   = 6'd32;
                        state_d    = StTxBit;
                    end else if (respond_enable && (cmd_byte_q == 8'h00 || cmd_byte_q == 8'hFF)) begin
                        tx_shift_d = {STATUS_WORD, 8'h00};
                        tx_len_d   = 6'd24;
                        state_d    = StTxBit;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StTxBit: begin
                if (timer_q == SlotEnd) begin
                    timer_d    = 16'd0;
                    tx_shift_d = {tx_shift_q[30:0], 1'b0};
                    tx_cnt_d   = tx_cnt_q + 6'd1;
                    if (tx_cnt_q == tx_len_q - 6'd1) begin
                        state_d = StTxStop;
                    end
                end
            end
            StTxStop: begin
                if (timer_q == SampleAt) begin
                    state_d = StIdle;
                end
            end
            StWaitIdle: begin
                if (pin_sync_q && high_cnt_q >= HighMax) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Drive is derived from next-state values so the pin lines up with the slot timer.
        drive_low_d = 1'b0;
        if (state_d == StTxBit) begin
            drive_low_d = timer_d < (tx_shift_d[31] ? T1 : T3);
        end else if (state_d == StTxStop) begin
            drive_low_d = timer_d < T2;
        end
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            timer_q     <= 16'd0;
            high_cnt_q  <= 16'd0;
            bit_cnt_q   <= 4'd0;
            sampled_q   <= 1'b0;
            rx_shift_q  <= 8'd0;
            cmd_byte_q  <= 8'd0;
            cmd_valid_q <= 1'b0;
            reset_req_q <= 1'b0;
            rx_error_q  <= 1'b0;
            busy_q      <= 1'b0;
            drive_low_q <= 1'b0;
            tx_shift_q  <= 32'd0;
            tx_len_q    <= 6'd0;
            tx_cnt_q    <= 6'd0;
            pin_meta_q  <= 1'b1;
            pin_sync_q  <= 1'b1;
            pin_prev_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            high_cnt_q  <= high_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            sampled_q   <= sampled_d;
            rx_shift_q  <= rx_shift_d;
            cmd_byte_q  <= cmd_byte_d;
            cmd_valid_q <= cmd_valid_d;
            reset_req_q <= reset_req_d;
            rx_error_q  <= rx_error_d;
            busy_q      <= busy_d;
            drive_low_q <= drive_low_d;
            tx_shift_q  <= tx_shift_d;
            tx_len_q    <= tx_len_d;
            tx_cnt_q    <= tx_cnt_d;
            pin_meta_q  <= fab_pin;
            pin_sync_q  <= pin_meta_q;
            pin_prev_q  <= pin_sync_q;
        end
    end

endmodule

// File: tb/tb_n64_controller_responder.sv
// Bench for n64_controller_responder: a bit-banging host plus a pin monitor that records the
// responder's low pulses, checked against a command-level reply model.
module tb_n64_controller_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        host_low;
    logic [31:0] button_data;
    logic        respond_enable;
    logic [7:0]  cmd_byte;
    logic        cmd_valid, reset_req, busy, rx_error;
    wire         fab_pin;

    pullup (fab_pin);
    assign fab_pin = host_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    n64_controller_responder dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fab_pin        (fab_pin),
        .button_data    (button_data),
        .respond_enable (respond_enable),
        .cmd_byte       (cmd_byte),
        .cmd_valid      (cmd_valid),
        .reset_req      (reset_req),
        .busy           (busy),
        .rx_error       (rx_error)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int stop_rel = 0;
    int cv_cnt = 0, rr_cnt = 0, rr_cv_cnt = 0, err_cnt = 0, last_err_cyc = 0, fall_cnt = 0;
    logic [7:0] cv_byte = 8'h00;
    int run_start[$];
    int run_len[$];
    int cur_len = 0, cur_start = 0;

    // Pin/pulse monitor; runs on the inactive edge.
    always @(negedge clk) begin
        if (cmd_valid) begin
            cv_cnt++;
            cv_byte = cmd_byte;
            if (reset_req) rr_cv_cnt++;
        end
        if (reset_req) rr_cnt++;
        if (rx_error) begin
            err_cnt++;
            last_err_cyc = cyc;
        end
        if (fab_pin === 1'b0 && !host_low) begin
            if (cur_len == 0) begin
                cur_start = cyc;
                fall_cnt++;
            end
            cur_len++;
        end else if (cur_len > 0) begin
            run_start.push_back(cur_start);
            run_len.push_back(cur_len);
            cur_len = 0;
        end
        cyc++;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic int model_bits(input logic [7:0] c, input logic en);
        if (!en) return 0;
        if (c == 8'h01) return 32;
        if (c == 8'h00 || c == 8'hFF) return 24;
        return 0;
    endfunction

    function automatic logic [31:0] model_word(input logic [7:0] c, input logic [31:0] b);
        return (c == 8'h01) ? b : 32'h0005_0002;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic host_bit(input logic b);
        host_low = 1'b1;
        cycles(b ? 100 : 300);
        host_low = 1'b0;
        cycles(b ? 300 : 100);
    endtask

    task automatic host_frame(input logic [7:0] c);
        for (int i = 7; i >= 0; i--) host_bit(c[i]);
        host_low = 1'b1;
        cycles(100);
        host_low = 1'b0;
        stop_rel = cyc;
    endtask

    task automatic run_cmd(input logic [7:0] c, output logic timed_out);
        int n;
        run_start.delete();
        run_len.delete();
        host_frame(c);
        cycles(5);
        n = 0;
        while (busy && n < 20000) begin
            cycles(1);
            n++;
        end
        timed_out = busy;
        cycles(4);
    endtask

    task automatic decode(output int nb, output logic [31:0] w, output logic tim_ok,
                          output int first_start, output int stop_len);
        logic b;
        nb = 0;
        w = 32'd0;
        tim_ok = 1'b1;
        first_start = -1;
        stop_len = 0;
        if (run_len.size() == 0) return;
        nb = run_len.size() - 1;
        first_start = run_start[0];
        stop_len = run_len[nb];
        for (int i = 0; i < nb; i++) begin
            b = (run_len[i] < 200);
            w = {w[30:0], b};
            if (run_len[i] != (b ? 100 : 300)) tim_ok = 1'b0;
            if (run_start[i+1] - run_start[i] != 400) tim_ok = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        host_low = 1'b0;
        respond_enable = 1'b1;
        button_data = 32'd0;
        cycles(3);
        rst_n = 1'b1;
        cycles(1);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++;
        if (cmd_byte !== 8'h00) begin failures++; $display("FAIL reset_cmd_byte got=%h want=00", cmd_byte); end
        checks++;
        if ({cmd_valid, reset_req, rx_error} !== 3'b000) begin
            failures++;
            $display("FAIL reset_pulses got=%b want=000", {cmd_valid, reset_req, rx_error});
        end
        checks++;
        if (fab_pin !== 1'b1) begin failures++; $display("FAIL reset_pin got=%b want=1", fab_pin); end
    endtask

    task automatic test_poll;
        int cv0, rr0, nb, fs, sl;
        logic to, tok;
        logic [31:0] w;
        cv0 = cv_cnt;
        rr0 = rr_cnt;
        button_data = 32'h8000_1234;
        respond_enable = 1'b1;
        run_cmd(8'h01, to);
        decode(nb, w, tok, fs, sl);
        checks++;
        if (to) begin failures++; $display("FAIL poll_busy_timeout got=busy want=idle"); end
        checks++;
        if (cv_cnt - cv0 != 1) begin failures++; $display("FAIL poll_cmd_valid got=%0d want=1", cv_cnt - cv0); end
        checks++;
        if (cv_byte !== 8'h01) begin failures++; $display("FAIL poll_cmd_byte got=%h want=01", cv_byte); end
        checks++;
        if (rr_cnt != rr0) begin failures++; $display("FAIL poll_reset_req got=%0d want=0", rr_cnt - rr0); end
        checks++;
        if (nb != 32) begin failures++; $display("FAIL poll_nbits got=%0d want=32", nb); end
        checks++;
        if (w !== 32'h8000_1234) begin failures++; $display("FAIL poll_word got=%h want=80001234", w); end
        checks++;
        if (!tok) begin failures++; $display("FAIL poll_bit_timing got=bad want=100/300"); end
        checks++;
        if (fs - stop_rel < 200 || fs - stop_rel > 206) begin
            failures++;
            $display("FAIL poll_turnaround got=%0d want=200..206", fs - stop_rel);
        end
        checks++;
        if (sl != 200) begin failures++; $display("FAIL poll_stop_len got=%0d want=200", sl); end
        checks++;
        if (fab_pin !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL poll_release got=pin%b/busy%b want=pin1/busy0", fab_pin, busy);
        end
    endtask

    task automatic test_status;
        int cv0, rr0, rc0, nb, fs, sl;
        logic to, tok;
        logic [31:0] w;
        logic [7:0] cmds [2];
        cmds[0] = 8'hFF;
        cmds[1] = 8'h00;
        respond_enable = 1'b1;
        for (int k = 0; k < 2; k++) begin
            cv0 = cv_cnt;
            rr0 = rr_cnt;
            rc0 = rr_cv_cnt;
            run_cmd(cmds[k], to);
            decode(nb, w, tok, fs, sl);
            checks++;
            if (cv_cnt - cv0 != 1 || cv_byte !== cmds[k] || to) begin
                failures++;
                $display("FAIL status_cmd got=%0d/%h want=1/%h", cv_cnt - cv0, cv_byte, cmds[k]);
            end
            checks++;
            if (rr_cnt - rr0 != ((cmds[k] == 8'hFF) ? 1 : 0) || rr_cv_cnt - rc0 != rr_cnt - rr0) begin
                failures++;
                $display("FAIL status_reset_req got=%0d/%0d want=%0d", rr_cnt - rr0, rr_cv_cnt - rc0,
                         (cmds[k] == 8'hFF) ? 1 : 0);
            end
            checks++;
            if (nb != 24 || w !== 32'h0005_0002) begin
                failures++;
                $display("FAIL status_reply got=%0d bits %h want=24 bits 050002", nb, w);
            end
            checks++;
            if (!tok || sl != 200) begin
                failures++;
                $display("FAIL status_timing got=ok%b/stop%0d want=ok1/stop200", tok, sl);
            end
        end
    endtask

    task automatic test_no_reply;
        int cv0, nb, fs, sl;
        logic to, tok;
        logic [31:0] w;
        logic [7:0] cmds [2];
        logic ens [2];
        cmds[0] = 8'h02; ens[0] = 1'b1;
        cmds[1] = 8'h01; ens[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            respond_enable = ens[k];
            cv0 = cv_cnt;
            run_cmd(cmds[k], to);
            decode(nb, w, tok, fs, sl);
            checks++;
            if (cv_cnt - cv0 != 1 || cv_byte !== cmds[k]) begin
                failures++;
                $display("FAIL noreply_cmd got=%0d/%h want=1/%h", cv_cnt - cv0, cv_byte, cmds[k]);
            end
            checks++;
            if (run_len.size() != 0) begin
                failures++;
                $display("FAIL noreply_pin_driven got=%0d pulses want=0", run_len.size());
            end
            checks++;
            if (to || busy !== 1'b0) begin failures++; $display("FAIL noreply_busy got=%b want=0", busy); end
        end
        respond_enable = 1'b1;
    endtask

    task automatic test_abort;
        int e0, cv0, rel, n;
        logic [3:0] lead;
        lead = 4'b1011;
        e0 = err_cnt;
        cv0 = cv_cnt;
        for (int i = 3; i >= 0; i--) host_bit(lead[i]);
        host_low = 1'b1;
        cycles(300);
        host_low = 1'b0;
        rel = cyc;
        n = 0;
        while (err_cnt == e0 && n < 1500) begin
            cycles(1);
            n++;
        end
        cycles(2);
        checks++;
        if (err_cnt - e0 != 1) begin failures++; $display("FAIL abort_rx_error got=%0d want=1", err_cnt - e0); end
        checks++;
        if (last_err_cyc - rel < 798 || last_err_cyc - rel > 808) begin
            failures++;
            $display("FAIL abort_delay got=%0d want=798..808", last_err_cyc - rel);
        end
        checks++;
        if (busy !== 1'b0 || cv_cnt != cv0) begin
            failures++;
            $display("FAIL abort_idle got=busy%b/cv%0d want=busy0/cv0", busy, cv_cnt - cv0);
        end
    endtask

    task automatic test_snapshot;
        int cv0, f0, nb, fs, sl;
        logic to, tok;
        logic [31:0] w;
        button_data = 32'hFFFF_FFFF;
        respond_enable = 1'b1;
        cv0 = cv_cnt;
        f0 = fall_cnt;
        fork
            run_cmd(8'h01, to);
            begin
                int n = 0;
                while (fall_cnt - f0 < 11 && n < 20000) begin
                    cycles(1);
                    n++;
                end
                button_data = 32'h0000_0000;
            end
        join
        decode(nb, w, tok, fs, sl);
        checks++;
        if (cv_cnt - cv0 != 1 || cv_byte !== 8'h01 || to) begin
            failures++;
            $display("FAIL snap_cmd got=%0d/%h want=1/01", cv_cnt - cv0, cv_byte);
        end
        checks++;
        if (nb != 32 || w !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL snap_word got=%0d bits %h want=32 bits ffffffff", nb, w);
        end
        checks++;
        if (!tok) begin failures++; $display("FAIL snap_timing got=bad want=100/300"); end
    endtask

    task automatic test_reset_tx;
        int f0, n;
        button_data = 32'hA5A5_A5A5;
        respond_enable = 1'b1;
        f0 = fall_cnt;
        host_frame(8'h01);
        n = 0;
        while (fall_cnt - f0 < 3 && n < 5000) begin
            cycles(1);
            n++;
        end
        cycles(50);
        checks++;
        if (fab_pin !== 1'b0) begin failures++; $display("FAIL rsttx_in_tx got=%b want=0", fab_pin); end
        rst_n = 1'b0;
        cycles(1);
        rst_n = 1'b1;
        checks++;
        if (fab_pin !== 1'b1) begin failures++; $display("FAIL rsttx_pin got=%b want=1", fab_pin); end
        checks++;
        if (busy !== 1'b0 || cmd_byte !== 8'h00) begin
            failures++;
            $display("FAIL rsttx_state got=busy%b/cmd%h want=busy0/cmd00", busy, cmd_byte);
        end
        cycles(20);
    endtask

    task automatic test_random;
        int cv0, rr0, nb, fs, sl, enb;
        logic to, tok, en;
        logic [31:0] w, b;
        logic [7:0] c;
        logic [7:0] picks [3];
        picks[0] = 8'h00;
        picks[1] = 8'h01;
        picks[2] = 8'hFF;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                c = picks[$urandom_range(0, 2)];
                en = 1'b1;
            end else begin
                c = 8'($urandom_range(2, 254));
                en = 1'($urandom_range(0, 1));
            end
            b = $urandom;
            button_data = b;
            respond_enable = en;
            enb = model_bits(c, en);
            cv0 = cv_cnt;
            rr0 = rr_cnt;
            run_cmd(c, to);
            decode(nb, w, tok, fs, sl);
            checks++;
            if (cv_cnt - cv0 != 1 || cv_byte !== c || to) begin
                failures++;
                $display("FAIL rand_cmd got=%0d/%h want=1/%h", cv_cnt - cv0, cv_byte, c);
            end
            checks++;
            if (rr_cnt - rr0 != ((c == 8'hFF) ? 1 : 0)) begin
                failures++;
                $display("FAIL rand_reset_req got=%0d cmd=%h", rr_cnt - rr0, c);
            end
            checks++;
            if (nb != enb) begin
                failures++;
                $display("FAIL rand_nbits got=%0d want=%0d cmd=%h en=%b", nb, enb, c, en);
            end
            if (enb > 0) begin
                checks++;
                if (w !== model_word(c, b) || !tok || sl != 200) begin
                    failures++;
                    $display("FAIL rand_reply got=%h ok%b stop%0d want=%h ok1 stop200", w, tok, sl,
                             model_word(c, b));
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        host_low = 1'b0;
        respond_enable = 1'b1;
        button_data = 32'd0;
        test_reset();
        test_poll();
        test_status();
        test_no_reply();
        test_abort();
        test_snapshot();
        test_reset_tx();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
